// File: rtl/md_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// md_sequencer_pkg
// Purpose : Shared constants for the iterative RV32M multiply/divide unit.
//           Holds the funct3 opcode encodings, the sequencer state encodings
//           and small opcode-decode helpers used by the FSM and datapath.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package md_sequencer_pkg;

  // Default operand/result width; the iteration count equals this width.
  localparam int MD_XLEN = 32;

  // RV32M funct3 encodings.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_PREP = 3'd1,
    MD_ITER = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_e;

  // funct3[2] separates the divide group from the multiply group.
  function automatic logic md_is_div(input md_op_e op);
    return op[2];
  endfunction

  // REM/REMU return the remainder; remainder sign follows the dividend.
  function automatic logic md_is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  // Operand a is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic md_a_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // Operand b is treated as signed for MULH, DIV and REM.
  function automatic logic md_b_signed(input md_op_e op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage : md_sequencer_pkg

// File: rtl/md_sequencer_if.sv
// -----------------------------------------------------------------------------
// md_sequencer_if
// Purpose : Pipeline <-> multiply/divide unit handshake bundle.
// Signals : start      request, sampled only while the unit is idle
//           md_op      RV32M funct3 opcode
//           operand_a  rs1 (multiplicand / dividend)
//           operand_b  rs2 (multiplier / divisor)
//           kill       pipeline flush, aborts an op in flight
//           busy       op in flight (PREP/ITER/FIX)
//           done       one-cycle pulse, result valid
//           result     registered result, held until the next done
//           stall_req  hold request for the hazard logic
// Modports: master = pipeline side, slave = md_sequencer side
// -----------------------------------------------------------------------------
interface md_sequencer_if #(
  parameter int XLEN = 32
);
  import md_sequencer_pkg::*;

  logic            start;
  md_op_e          md_op;
  logic [XLEN-1:0] operand_a;
  logic [XLEN-1:0] operand_b;
  logic            kill;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  logic            stall_req;

  modport master (
    output start, md_op, operand_a, operand_b, kill,
    input  busy, done, result, stall_req
  );

  modport slave (
    input  start, md_op, operand_a, operand_b, kill,
    output busy, done, result, stall_req
  );

endinterface : md_sequencer_if

// File: rtl/md_sequencer_step.sv
// -----------------------------------------------------------------------------
// md_sequencer_step
// Purpose : Combinational single-iteration datapath of the sequencer.
//           Multiply: add-shift on a 2*XLEN product register.
//           Divide  : restoring trial-subtract on an (XLEN+1)-bit partial
//                     remainder; the low half of acc holds the dividend bits
//                     still to be consumed and collects quotient bits.
// Ports   : is_div_i  select divide step (1) or multiply step (0)
//           opnd_i    multiplicand (multiply) or divisor (divide) magnitude
//           acc_i/o   product register / dividend-quotient shift register
//           rem_i/o   partial remainder
// -----------------------------------------------------------------------------
module md_sequencer_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN:0]     rem_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN:0]     rem_o
);

  logic [XLEN:0]   mul_sum;    // XLEN+1 bits keeps the carry out of the add
  logic [XLEN+1:0] div_shift;  // one extra bit so the trial difference has a sign
  logic [XLEN+1:0] div_diff;

  always_comb begin
    mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    div_shift = {rem_i, acc_i[XLEN-1]};
    div_diff  = div_shift - {2'b00, opnd_i};

    if (is_div_i) begin
      if (!div_diff[XLEN+1]) begin
        rem_o = div_diff[XLEN:0];
        acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b1};
      end else begin
        // Restore: keep the shifted remainder, quotient bit 0.
        rem_o = div_shift[XLEN:0];
        acc_o = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      // Carry lands in the MSB as the whole register shifts right by one.
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
      rem_o = rem_i;
    end
  end

endmodule : md_sequencer_step

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
// Purpose : Iterative RV32M multiply/divide unit beside the EX-stage ALU.
//           IDLE -> PREP -> ITER (XLEN cycles) -> FIX -> DONE, with divide
//           special cases (divide by zero, signed overflow) short-cut from
//           PREP straight to DONE. Raises stall_req while an op is in flight.
// Ports   : clk    system clock, rising edge
//           reset  asynchronous active-high reset
//           md     md_sequencer_if.slave handshake bundle
// -----------------------------------------------------------------------------
module md_sequencer
  import md_sequencer_pkg::*;
#(
  parameter int XLEN = MD_XLEN
) (
  input  logic          clk,
  input  logic          reset,
  md_sequencer_if.slave md
);

  localparam int CW = $clog2(XLEN);
  localparam int PW = 2 * XLEN;

  md_state_e       state_q, state_d;
  md_op_e          op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;        // latched raw operands
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [PW-1:0]   acc_q, acc_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;    // final result needs negation
  logic [XLEN-1:0] result_q, result_d;

  logic            busy;
  logic            done_pulse;

  // PREP-time decode of the latched operands.
  logic            is_div;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;

  // FIX-time sign-corrected results.
  logic [PW-1:0]   prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix;

  logic [PW-1:0]   step_acc;
  logic [XLEN:0]   step_rem;

  assign is_div   = md_is_div(op_q);
  assign a_neg    = md_a_signed(op_q) & a_q[XLEN-1];
  assign b_neg    = md_b_signed(op_q) & b_q[XLEN-1];
  assign a_mag    = a_neg ? (~a_q + XLEN'(1)) : a_q;
  assign b_mag    = b_neg ? (~b_q + XLEN'(1)) : b_q;
  assign div_zero = (b_q == '0);
  assign div_ovf  = ((op_q == MD_DIV) || (op_q == MD_REM)) &&
                    (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);

  assign prod_fix = neg_q ? (~acc_q + PW'(1)) : acc_q;
  assign quot_fix = neg_q ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
  assign rem_fix  = neg_q ? (~rem_q[XLEN-1:0] + XLEN'(1)) : rem_q[XLEN-1:0];

  md_sequencer_step #(
    .XLEN (XLEN)
  ) u_step (
    .is_div_i (is_div),
    .opnd_i   (opnd_q),
    .acc_i    (acc_q),
    .rem_i    (rem_q),
    .acc_o    (step_acc),
    .rem_o    (step_rem)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q     <= MD_MUL;
      a_q      <= '0;
      b_q      <= '0;
      opnd_q   <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    cnt_d      = cnt_q;
    neg_d      = neg_q;
    result_d   = result_q;
    busy       = 1'b0;
    done_pulse = 1'b0;

    case (state_q)
      MD_IDLE: begin
        if (md.start && !md.kill) begin
          op_d    = md.md_op;
          a_d     = md.operand_a;
          b_d     = md.operand_b;
          state_d = MD_PREP;
        end
      end

      MD_PREP: begin
        busy = 1'b1;
        if (md.kill) begin
          state_d = MD_IDLE;
        end else if (is_div && (div_zero || div_ovf)) begin
          // Divide-by-zero takes precedence; the overflow pair has b != 0.
          if (div_zero) begin
            result_d = md_is_rem(op_q) ? a_q : '1;
          end else begin
            result_d = md_is_rem(op_q) ? '0 : a_q;
          end
          state_d = MD_DONE;
        end else begin
          cnt_d = CW'(XLEN - 1);
          neg_d = md_is_rem(op_q) ? a_neg : (a_neg ^ b_neg);
          rem_d = '0;
          if (is_div) begin
            opnd_d = b_mag;
            acc_d  = {{XLEN{1'b0}}, a_mag};
          end else begin
            opnd_d = a_mag;
            acc_d  = {{XLEN{1'b0}}, b_mag};
          end
          state_d = MD_ITER;
        end
      end

      MD_ITER: begin
        busy = 1'b1;
        if (md.kill) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = step_acc;
          rem_d = step_rem;
          if (cnt_q == '0) begin
            state_d = MD_FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end

      MD_FIX: begin
        busy = 1'b1;
        if (md.kill) begin
          state_d = MD_IDLE;
        end else begin
          case (op_q)
            MD_MUL:                       result_d = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result_d = prod_fix[PW-1:XLEN];
            MD_DIV, MD_DIVU:              result_d = quot_fix;
            default:                      result_d = rem_fix;
          endcase
          state_d = MD_DONE;
        end
      end

      MD_DONE: begin
        done_pulse = 1'b1;
        state_d    = MD_IDLE;
      end

      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  assign md.busy      = busy;
  assign md.done      = done_pulse;
  assign md.result    = result_q;
  assign md.stall_req = ((state_q == MD_IDLE) && md.start && !md.kill) || busy;

endmodule : md_sequencer

// File: tb/tb_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_md_sequencer
// Purpose : Directed self-checking bench for md_sequencer. Cycle numbering:
//           the edge that samples start is edge 0; cycle n is the interval
//           right after edge n-1. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_md_sequencer;
  import md_sequencer_pkg::*;

  localparam int XLEN = 32;
  localparam int NORM = 35;  // done cycle of a full-length op
  localparam int SPEC = 2;   // done cycle of a special-case divide

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] last_res;

  md_sequencer_if #(.XLEN(XLEN)) mif ();

  md_sequencer #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One complete transaction: start at edge 0, watch exp_cyc+4 cycles.
  // poke_cyc != 0 raises a second start across edge poke_cyc-1 (while busy).
  task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_cyc, input int poke_cyc);
    int first_done;
    int n_done;
    int busy_bad;
    int stall_bad;
    logic exp_busy;
    first_done = 0;
    n_done     = 0;
    busy_bad   = 0;
    stall_bad  = 0;
    @(negedge clk);
    mif.start     = 1'b1;
    mif.md_op     = op;
    mif.operand_a = a;
    mif.operand_b = b;
    @(posedge clk);
    #1;
    // Operand/opcode changes after acceptance must not matter.
    mif.start     = 1'b0;
    mif.md_op     = (op == MD_MUL) ? MD_REMU : MD_MUL;
    mif.operand_a = ~a;
    mif.operand_b = 32'h0000_0001;
    for (int c = 1; c <= exp_cyc + 4; c++) begin
      if (c == poke_cyc) begin
        mif.start     = 1'b1;
        mif.operand_a = 32'h0000_1234;
        mif.operand_b = 32'h0000_0005;
      end
      @(negedge clk);
      exp_busy = (c < exp_cyc);
      if (mif.done === 1'b1) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (mif.busy !== exp_busy) busy_bad++;
      if (mif.stall_req !== exp_busy) stall_bad++;
      mif.start = 1'b0;
    end
    check({tag, "_done_cycle"}, first_done, exp_cyc);
    check({tag, "_done_count"}, n_done, 1);
    check({tag, "_busy_window"}, busy_bad, 0);
    check({tag, "_stall_window"}, stall_bad, 0);
    check({tag, "_result"}, mif.result, exp_res);
    last_res = exp_res;
    $display("txn %s op=%0d a=%h b=%h result=%h done_cycle=%0d",
             tag, op, a, b, mif.result, first_done);
  endtask

  initial begin
    int n_done;
    reset         = 1'b1;
    mif.start     = 1'b0;
    mif.kill      = 1'b0;
    mif.md_op     = MD_MUL;
    mif.operand_a = '0;
    mif.operand_b = '0;
    last_res      = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", mif.busy, 0);
    check("reset_done", mif.done, 0);
    check("reset_result", mif.result, 0);
    check("reset_stall", mif.stall_req, 0);
    reset = 1'b0;

    // Multiply family
    run_op("mul_7_m3",  MD_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, NORM, 0);
    run_op("mulhu_ff",  MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, NORM, 0);
    run_op("mulh_ff",   MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, NORM, 0);
    run_op("mulhsu_ff", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, NORM, 0);

    // Divide special cases
    run_op("div_by0",   MD_DIV, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, SPEC, 0);
    run_op("rem_by0",   MD_REM, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, SPEC, 0);
    run_op("div_ovf",   MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC, 0);
    run_op("rem_ovf",   MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, SPEC, 0);

    // Divide family
    run_op("div_m7_2",  MD_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, NORM, 0);
    run_op("rem_m7_2",  MD_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, NORM, 0);
    run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd14, NORM, 0);
    run_op("remu_100_7", MD_REMU, 32'd100, 32'd7, 32'd2,  NORM, 0);

    // Kill in the 10th ITER cycle (cycle 11)
    @(negedge clk);
    mif.start     = 1'b1;
    mif.md_op     = MD_MUL;
    mif.operand_a = 32'd5;
    mif.operand_b = 32'd6;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (11) @(negedge clk);
    check("kill_pre_busy", mif.busy, 1);
    mif.kill = 1'b1;
    @(posedge clk);
    #1 mif.kill = 1'b0;
    @(negedge clk);
    check("kill_busy", mif.busy, 0);
    check("kill_done", mif.done, 0);
    check("kill_result", mif.result, last_res);
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mif.done === 1'b1) n_done++;
    end
    check("kill_no_done", n_done, 0);
    check("kill_result_held", mif.result, last_res);
    $display("txn kill_iter result=%h dones_after_kill=%0d", mif.result, n_done);

    run_op("divu_9_3", MD_DIVU, 32'd9, 32'd3, 32'd3, NORM, 0);

    // start and kill together in IDLE
    @(negedge clk);
    mif.start     = 1'b1;
    mif.kill      = 1'b1;
    mif.md_op     = MD_DIVU;
    mif.operand_a = 32'd9;
    mif.operand_b = 32'd3;
    #1;
    check("startkill_stall", mif.stall_req, 0);
    @(posedge clk);
    #1;
    mif.start = 1'b0;
    mif.kill  = 1'b0;
    @(negedge clk);
    check("startkill_busy", mif.busy, 0);
    check("startkill_done", mif.done, 0);
    $display("txn start_kill_idle busy=%0b stall=%0b", mif.busy, mif.stall_req);

    // Asynchronous reset in the middle of ITER
    @(negedge clk);
    mif.start     = 1'b1;
    mif.md_op     = MD_MUL;
    mif.operand_a = 32'd5;
    mif.operand_b = 32'd6;
    @(posedge clk);
    #1 mif.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", mif.busy, 0);
    check("arst_done", mif.done, 0);
    check("arst_result", mif.result, 0);
    check("arst_stall", mif.stall_req, 0);
    $display("txn async_reset busy=%0b done=%0b result=%h", mif.busy, mif.done, mif.result);
    @(negedge clk);
    reset = 1'b0;

    // Second start while busy must be ignored
    run_op("mul_3_4_poke", MD_MUL, 32'd3, 32'd4, 32'd12, NORM, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_md_sequencer
